// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep controller.
//   - FSM state encoding
//   - truth-table geometry (3 inputs, 8 rows)
//   - settle counter width
package tt_pkg;

  localparam int TT_N_IN   = 3;
  localparam int TT_N_ROWS = 8;
  localparam int TT_WAIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } tt_state_e;

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter with zero flag; times the settle (WAIT) phase.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        load cnt with load_val_i (has priority over dec_i)
//   dec_i         decrement, saturating at zero
//   load_val_i    value loaded on load_i
//   zero_o        count is zero
module tt_settle_counter
  import tt_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 dec_i,
  input  logic [TT_WAIT_W-1:0] load_val_i,
  output logic                 zero_o
);

  logic [TT_WAIT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                       cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: on start, drives {a,b,c} through rows
// 000..111, samples s per row into result[row], and compares the vector
// with the expected pattern latched at start.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            sweep request (only honoured in IDLE)
//   expected[7:0]    expected s per row, latched at accepted start
//   tt_a/tt_b/tt_c   row index driven to the datapath (a = MSB)
//   tt_s             datapath output
//   busy             sweep in progress (through the DONE cycle)
//   done             one-cycle completion pulse
//   result[7:0]      sampled s vector
//   pass             result == expected, valid from done until next start
//   fail_idx[2:0]    first mismatching row (only with TT_SWEEP_EARLY_ABORT_EN)
// Build option: define TT_SWEEP_EARLY_ABORT_EN to stop at the first
// mismatching row and report it on fail_idx.
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       tt_a,
  output logic       tt_b,
  output logic       tt_c,
  input  logic       tt_s,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass
`ifdef TT_SWEEP_EARLY_ABORT_EN
  ,
  output logic [2:0] fail_idx
`endif
);

  localparam int N_ROWS = TT_N_ROWS;
  localparam logic [TT_N_IN-1:0] LAST_ROW = TT_N_IN'(N_ROWS - 1);
  // WAIT lasts WAIT_CYCLES cycles: loaded with N-1, exits on zero.
  localparam logic [TT_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? TT_WAIT_W'(WAIT_CYCLES - 1) : '0;

  tt_state_e           state_q;
  logic [TT_N_IN-1:0]  row_q;
  logic [TT_N_IN-1:0]  tt_q;
  logic [7:0]          exp_q;
  logic [7:0]          result_q;
  logic                pass_q;
  logic                done_q;
  logic                busy_q;
  logic                wait_zero;
  logic [7:0]          smp_vec;

  tt_settle_counter u_settle (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (state_q == ST_APPLY),
    .dec_i      (state_q == ST_WAIT),
    .load_val_i (WAIT_LOAD),
    .zero_o     (wait_zero)
  );

  // Result vector including the current sample; pass on the last row is
  // evaluated from this so the row-7 bit is not lost.
  always_comb begin
    smp_vec         = result_q;
    smp_vec[row_q]  = tt_s;
  end

`ifdef TT_SWEEP_EARLY_ABORT_EN
  logic [2:0] fail_q;
  assign fail_idx = (done_q && !pass_q) ? fail_q : 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      tt_q     <= '0;
      exp_q    <= '0;
      result_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TT_SWEEP_EARLY_ABORT_EN
      fail_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_APPLY;
            row_q    <= '0;
            result_q <= '0;
            exp_q    <= expected;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
`ifdef TT_SWEEP_EARLY_ABORT_EN
            fail_q   <= '0;
`endif
          end
        end
        ST_APPLY: begin
          tt_q    <= row_q;
          state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_SAMPLE;
        end
        ST_WAIT: begin
          if (wait_zero) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          result_q <= smp_vec;
`ifdef TT_SWEEP_EARLY_ABORT_EN
          if (tt_s != exp_q[row_q]) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= row_q;
          end else
`endif
          if (row_q == LAST_ROW) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (smp_vec == exp_q);
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tt_a   = tt_q[2];
  assign tt_b   = tt_q[1];
  assign tt_c   = tt_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign pass   = pass_q;

endmodule
